// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-granular memory bus between the I-cache and D-cache.
// Holds each grant until the memory completes, with a sticky watchdog for hung transactions.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned LINE_WIDTH     = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   // port I
   input  logic                  i_command_valid,
   input  logic                  i_command_store,
   input  logic [ADDR_WIDTH-1:0] i_command_addr,
   input  logic [LINE_WIDTH-1:0] i_data_to_bus,
   output logic [LINE_WIDTH-1:0] i_data_from_bus,
   output logic                  i_bus_valid,
   output logic                  i_bus_ready,
   // port D
   input  logic                  d_command_valid,
   input  logic                  d_command_store,
   input  logic [ADDR_WIDTH-1:0] d_command_addr,
   input  logic [LINE_WIDTH-1:0] d_data_to_bus,
   output logic [LINE_WIDTH-1:0] d_data_from_bus,
   output logic                  d_bus_valid,
   output logic                  d_bus_ready,
   // memory side
   output logic                  mem_command_valid,
   output logic                  mem_command_store,
   output logic                  mem_command_rready,
   output logic [ADDR_WIDTH-1:0] mem_command_addr,
   output logic [LINE_WIDTH-1:0] mem_data_to_bus,
   input  logic [LINE_WIDTH-1:0] mem_data_from_bus,
   input  logic                  mem_bus_valid,
   input  logic                  mem_bus_ready,
   // status
   output logic                  grant_d,
   output logic                  timeout_err
);

   localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StGrantI,
      StGrantD
   } state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic               r_last_grant;
   logic               w_last_grant_next;
   logic [WdogW-1:0]   r_wdog;
   logic               r_timeout_err;

   logic               w_sel_d;
   logic               w_granted;
   logic               w_store;
   logic               w_done;

   // Reset gates the datapath so nothing leaks out in the cycle reset is applied.
   always_comb begin
      w_sel_d   = (r_state == StGrantD);
      w_granted = (r_state != StIdle) && !reset;
      w_store   = w_sel_d ? d_command_store : i_command_store;
      w_done    = w_granted && (w_store ? mem_bus_ready : mem_bus_valid);
   end

   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      unique case (r_state)
         StIdle: begin
            if (i_command_valid && d_command_valid) begin
               w_state_next      = r_last_grant ? StGrantI : StGrantD;
               w_last_grant_next = !r_last_grant;
            end else if (i_command_valid) begin
               w_state_next      = StGrantI;
               w_last_grant_next = 1'b0;
            end else if (d_command_valid) begin
               w_state_next      = StGrantD;
               w_last_grant_next = 1'b1;
            end
         end
         StGrantI, StGrantD: begin
            if (w_done) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_last_grant <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // Watchdog saturates at its limit; the grant is never aborted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else if (r_state == StIdle) begin
         r_wdog <= '0;
      end else begin
         if (r_wdog != WdogMax) r_wdog <= r_wdog + 1'b1;
         if ((r_wdog == WdogMax) && !w_done) r_timeout_err <= 1'b1;
      end
   end

   always_comb begin
      mem_command_valid  = w_granted;
      mem_command_store  = w_granted && w_store;
      mem_command_rready = w_granted && !w_store;
      mem_command_addr   = '0;
      mem_data_to_bus    = '0;
      if (w_granted) begin
         mem_command_addr = w_sel_d ? d_command_addr : i_command_addr;
         mem_data_to_bus  = w_sel_d ? d_data_to_bus : i_data_to_bus;
      end
      i_data_from_bus = mem_data_from_bus;
      d_data_from_bus = mem_data_from_bus;
      i_bus_valid     = w_granted && !w_sel_d && !w_store && mem_bus_valid;
      i_bus_ready     = w_granted && !w_sel_d && w_store && mem_bus_ready;
      d_bus_valid     = w_granted && w_sel_d && !w_store && mem_bus_valid;
      d_bus_ready     = w_granted && w_sel_d && w_store && mem_bus_ready;
      grant_d         = (r_state == StGrantD);
      timeout_err     = r_timeout_err;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the instruction cache (port I) and the data cache (port D).
- Each cache's memory-bus port connects to one requester port unchanged; the downstream port drives the memory interface.
- Grants one line transaction (read fill or dirty writeback) at a time, round-robin between the two ports.
- The grant is held until the memory completes the transaction. A watchdog flags transactions that never complete.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- LINE_WIDTH, 1024, cache line width in bits (DATA_WIDTH*2**OFFSET_LENGTH = 64*16).
- TIMEOUT_CYCLES, 1024, cycles in a grant state without a response before timeout_err is set.

Ports:
- clk  in  1  clock; one clock domain. Already decided.
- reset  in  1  synchronous, active-high reset. Already decided.
- i_command_valid  in  1  port I request.
- i_command_store  in  1  port I: 1 = line write, 0 = line read.
- i_command_addr  in  ADDR_WIDTH  port I line address.
- i_data_to_bus  in  LINE_WIDTH  port I write line.
- i_data_from_bus  out  LINE_WIDTH  read line to port I.
- i_bus_valid  out  1  read-done pulse to port I.
- i_bus_ready  out  1  write-done pulse to port I.
- d_command_valid, d_command_store, d_command_addr, d_data_to_bus, d_data_from_bus, d_bus_valid, d_bus_ready: same as port I, for port D.
- mem_command_valid  out  1  downstream request.
- mem_command_store  out  1  downstream write flag.
- mem_command_rready  out  1  equals mem_command_valid & ~mem_command_store.
- mem_command_addr  out  ADDR_WIDTH  downstream address.
- mem_data_to_bus  out  LINE_WIDTH  downstream write line.
- mem_data_from_bus  in  LINE_WIDTH  downstream read line.
- mem_bus_valid  in  1  read-done pulse from memory.
- mem_bus_ready  in  1  write-done pulse from memory.
- grant_d  out  1  1 while port D owns the bus (debug/perf).
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D. Register last_grant (0 = I, 1 = D).
- Reset values: state=IDLE, last_grant=1 (port I wins the first tie), watchdog=0, timeout_err=0.
- Reset takes effect at the clock edge even mid-transaction. Any memory response arriving after reset is dropped.
- Outputs in IDLE and during reset: all mem_command_* = 0, mem_data_to_bus = 0, every i_/d_ bus_valid and bus_ready = 0.
- IDLE transitions:
  - Only one port has command_valid: go to that port's GRANT state.
  - Both ports valid: grant the port other than last_grant.
  - The granted port is stored in last_grant on the same edge.
  - Neither port valid: stay in IDLE.
- Latency: the requester's valid is seen in IDLE at edge N; mem_command_valid is 1 from cycle N+1.
- GRANT_x datapath:
  - mem_command_valid/store/addr and mem_data_to_bus are combinational copies of port x's inputs.
  - mem_command_valid is forced to 1 for the whole grant. A requester dropping valid mid-grant does not cancel the transaction.
  - The requester must hold store, addr and data stable while granted.
- Completion condition:
  - Read (store=0) completes on mem_bus_valid=1.
  - Write (store=1) completes on mem_bus_ready=1.
  - The "wrong" pulse type (e.g. ready during a read) is ignored.
- Completion response:
  - The pulse goes to port x only, in the same cycle (combinational): x_bus_valid or x_bus_ready.
  - State returns to IDLE at the next edge, leaving one idle cycle between transactions.
  - A port that immediately re-requests (fill followed by writeback) is re-arbitrated fairly. If the other port is waiting, the other port wins.
- Data and pulse routing:
  - mem_data_from_bus is broadcast to both i_data_from_bus and d_data_from_bus.
  - The port not granted always sees bus_valid=0 and bus_ready=0.
- Watchdog:
  - Counter cleared in IDLE; increments each cycle in a GRANT state.
  - When it reaches TIMEOUT_CYCLES - 1 without completion, timeout_err is set. It stays set until reset.
  - The grant is kept; the arbiter does not abort. The counter saturates.
- grant_d = (state == GRANT_D).

Test Plan:
- Single read on I: after reset, i_command_valid=1, store=0, addr=0x1000 at cycle 1. Expect mem_command_valid=1, addr=0x1000, rready=1 from cycle 2. mem_bus_valid at cycle 5 with line 0xA5... gives i_bus_valid=1 and i_data_from_bus=line in cycle 5, and d_bus_valid=0. Expect IDLE at cycle 6.
- Tie after reset: I and D both request in the same cycle. Expect I granted first and grant_d=0. After I completes, D is granted with grant_d=1, with exactly one IDLE cycle between.
- Round-robin under load: both ports request continuously for 6 transactions. Expect grant order I,D,I,D,I,D; neither port is granted twice in a row.
- D writeback: d_command_store=1, addr=0x2040, data pattern P. Expect mem_data_to_bus=P and mem_command_rready=0. A stray mem_bus_valid is ignored. mem_bus_ready gives d_bus_ready=1 and i_bus_ready=0.
- Reset mid-grant: reset asserted during GRANT_D. Next cycle, all mem_* outputs = 0 and state is IDLE. A late mem_bus_valid produces no i/d pulse. After reset, a tie goes to I.
- Watchdog: TIMEOUT_CYCLES=8, grant given, no response. Expect timeout_err=1 after the 8th grant cycle and held. A later mem_bus_valid still completes the transaction; timeout_err stays 1 until reset.
